// File: rtl/spi_rd_fifo_if.sv
// Bus between the word producer / SPI read block and the read FIFO.
// The master side drives data, write strobe, pop and status clear.
interface spi_rd_fifo_if #(
    parameter int Nbit = 8,
    parameter int AW   = 4
);
    logic [Nbit-1:0] din;
    logic            wr_en;
    logic            clr;
    logic            stat_clr;
    logic [Nbit-1:0] dout;
    logic            empty;
    logic            full;
    logic [AW:0]     count;
    logic            ovf;
    logic            udf;

    modport master (
        output din, wr_en, clr, stat_clr,
        input  dout, empty, full, count, ovf, udf
    );

    modport slave (
        input  din, wr_en, clr, stat_clr,
        output dout, empty, full, count, ovf, udf
    );
endinterface

// File: rtl/spi_rd_fifo.sv
// Read-side FIFO for the SPI slave: registered head word on dout, one pop per
// rising edge of clr, fill value while empty, sticky overflow/underflow flags.
module spi_rd_fifo #(
    parameter int              Nbit      = 8,
    parameter int              AW        = 4,
    parameter logic [Nbit-1:0] EMPTY_VAL = {Nbit{1'b1}}
) (
    input logic          clk,
    input logic          rst,
    spi_rd_fifo_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [Nbit-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   rd_nxt;
    logic [AW:0]     count_q, count_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic [Nbit-1:0] dout_q, dout_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            clr_d_q;
    logic            pop, pop_acc, wr_acc;

    assign pop     = bus.clr & ~clr_d_q;
    assign pop_acc = pop & ~empty_q;
    assign wr_acc  = bus.wr_en & (~full_q | pop_acc);
    assign rd_nxt  = rd_ptr_q + AW'(1);

    always_comb begin
        wr_ptr_d = wr_acc  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_acc ? rd_nxt : rd_ptr_q;
        count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop_acc);
        empty_d  = (count_d == '0);
        full_d   = (count_d == (AW+1)'(DEPTH));
        ovf_d    = (bus.wr_en & full_q & ~pop_acc) | (ovf_q & ~bus.stat_clr);
        udf_d    = (pop & empty_q) | (udf_q & ~bus.stat_clr);

        // Head only moves on a write into empty or an accepted pop, so the
        // read block always samples a stable word.
        dout_d = dout_q;
        if (empty_d)
            dout_d = EMPTY_VAL;
        else if (empty_q && wr_acc)
            dout_d = bus.din;
        else if (pop_acc)
            dout_d = (count_q == (AW+1)'(1)) ? bus.din : mem_q[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            dout_q   <= EMPTY_VAL;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            clr_d_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            clr_d_q  <= bus.clr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem_q[wr_ptr_q] <= bus.din;
    end

    assign bus.dout  = dout_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule

// File: tb/tb_spi_rd_fifo.sv
// Directed bench for spi_rd_fifo: a queue of expected words is pushed on each
// accepted write and popped on each accepted pop; all outputs checked per cycle.
module tb_spi_rd_fifo;
    localparam int Nbit  = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [Nbit-1:0] sb [$];
    logic            exp_ovf = 1'b0;
    logic            exp_udf = 1'b0;
    logic            clr_prev = 1'b0;

    spi_rd_fifo_if #(.Nbit(Nbit), .AW(AW)) bus ();

    spi_rd_fifo #(.Nbit(Nbit), .AW(AW), .EMPTY_VAL(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour evaluated at the clock edge on the values driven.
    task automatic model_edge(input logic w, input logic [Nbit-1:0] d, input logic c,
                              input logic s, input logic r);
        logic pop, pacc, wacc;
        if (r) begin
            sb.delete();
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
            clr_prev = 1'b0;
        end else begin
            pop  = c & ~clr_prev;
            pacc = pop && (sb.size() > 0);
            wacc = w && ((sb.size() < DEPTH) || pacc);
            exp_ovf = (w && !wacc) | (exp_ovf & ~s);
            exp_udf = (pop && sb.size() == 0) | (exp_udf & ~s);
            if (pacc) void'(sb.pop_front());
            if (wacc) sb.push_back(d);
            clr_prev = c;
        end
    endtask

    task automatic check_all(input string tag);
        logic [Nbit-1:0] head;
        head = (sb.size() > 0) ? sb[0] : 8'hFF;
        chk({tag, ".dout"},  32'(bus.dout),  32'(head));
        chk({tag, ".count"}, 32'(bus.count), 32'(sb.size()));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(sb.size() == 0));
        chk({tag, ".full"},  32'(bus.full),  32'(sb.size() == DEPTH));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(exp_ovf));
        chk({tag, ".udf"},   32'(bus.udf),   32'(exp_udf));
    endtask

    task automatic cyc(input string tag, input logic w, input logic [Nbit-1:0] d,
                       input logic c, input logic s = 1'b0, input logic r = 1'b0);
        bus.wr_en    = w;
        bus.din      = d;
        bus.clr      = c;
        bus.stat_clr = s;
        rst          = r;
        @(posedge clk);
        model_edge(w, d, c, s, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.din = '0; bus.clr = 1'b0; bus.stat_clr = 1'b0;
        cyc("rst0", 0, 8'h00, 0, 0, 1);
        cyc("rst1", 0, 8'h00, 0, 0, 1);

        cyc("wr11", 1, 8'h11, 0);
        chk("first_write_dout", 32'(bus.dout), 32'h11);
        cyc("wr22", 1, 8'h22, 0);
        cyc("wr33", 1, 8'h33, 0);
        chk("three_count", 32'(bus.count), 32'd3);

        for (int i = 0; i < 3; i++) begin
            cyc("pulse_hi", 0, 8'h00, 1);
            cyc("pulse_lo", 0, 8'h00, 0);
        end
        chk("drained_dout", 32'(bus.dout), 32'hFF);
        chk("drained_udf", 32'(bus.udf), 32'd0);

        cyc("wr44", 1, 8'h44, 0);
        cyc("wr55", 1, 8'h55, 0);
        for (int i = 0; i < 5; i++) cyc("hold_clr", 0, 8'h00, 1);
        chk("hold_one_pop", 32'(bus.count), 32'd1);
        cyc("hold_rel", 0, 8'h00, 0);
        cyc("hold_pop", 0, 8'h00, 1);
        cyc("hold_lo", 0, 8'h00, 0);

        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 8'(i), 0);
        cyc("ovf_wr", 1, 8'hAA, 0);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("order", 32'(bus.dout), 32'(i));
            cyc("drain_hi", 0, 8'h00, 1);
            cyc("drain_lo", 0, 8'h00, 0);
        end
        cyc("stat_clr", 0, 8'h00, 0, 1);
        chk("ovf_cleared", 32'(bus.ovf), 32'd0);

        for (int i = 0; i < DEPTH; i++) cyc("fill2", 1, 8'(8'h80 + i), 0);
        cyc("full_wr_pop", 1, 8'h55, 1);
        chk("full_wr_pop_cnt", 32'(bus.count), 32'd16);
        cyc("full_lo", 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("last_is_55", 32'(bus.dout), 32'h55);
            cyc("drain2_hi", 0, 8'h00, 1);
            cyc("drain2_lo", 0, 8'h00, 0);
        end

        cyc("stat_clr2", 0, 8'h00, 0, 1);
        cyc("empty_wr_pop", 1, 8'h5A, 1);
        chk("ewp_dout", 32'(bus.dout), 32'h5A);
        chk("ewp_udf", 32'(bus.udf), 32'd1);
        cyc("ewp_lo", 0, 8'h00, 0);
        cyc("ewp_pop", 0, 8'h00, 1);
        cyc("ewp_pop_lo", 0, 8'h00, 0);
        cyc("udf_vs_clr", 0, 8'h00, 1, 1);
        chk("event_wins", 32'(bus.udf), 32'd1);
        cyc("udf_vs_lo", 0, 8'h00, 0, 1);

        cyc("pre_a", 1, 8'hC0, 0);
        cyc("pre_b", 1, 8'hC1, 0);
        for (int i = 0; i < 40; i++) begin
            cyc("stream_hi", 1, 8'(i), 1);
            cyc("stream_lo", 0, 8'h00, 0);
        end
        cyc("mid_rst", 1, 8'hEE, 1, 0, 1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'hFF);
        cyc("post_rst_clr", 0, 8'h00, 1);
        chk("post_rst_udf", 32'(bus.udf), 32'd1);
        cyc("end", 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
